// File: rtl/multdiv_sched_if.sv
// Execute-stage request, multdiv handshake and writeback signals of the multdiv issue sequencer.
// The sequencer uses the slave view; the pipeline/multdiv side uses the master view.
interface multdiv_sched_if;
  logic        req_valid;
  logic        req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_rd;
  logic        flush;
  logic        stall;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_mult_exc;
  logic        md_div_exc;
  logic        md_rdy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exc;
  logic        timeout_err;

  modport master (
    output req_valid, req_op, req_a, req_b, req_rd, flush,
    output md_result, md_mult_exc, md_div_exc, md_rdy,
    input  stall, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    input  wb_valid, wb_rd, wb_data, wb_exc, timeout_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_rd, flush,
    input  md_result, md_mult_exc, md_div_exc, md_rdy,
    output stall, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    output wb_valid, wb_rd, wb_data, wb_exc, timeout_err
  );
endinterface

// File: rtl/multdiv_sched.sv
// Issue/writeback sequencer for the iterative multdiv unit: freezes the pipeline while the unit
// iterates and returns one writeback beat, redirecting exceptions to $rstatus (r30).
module multdiv_sched #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic           clock,
  input  logic           reset,
  multdiv_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [5:0] CNT_LIMIT   = 6'(TIMEOUT);
  localparam logic [5:0] CNT_UNMASK  = 6'd2;
  localparam logic [4:0] RSTATUS_REG = 5'd30;

  // Architectural status code written to $rstatus for a failed MULT (4) or DIV (5).
  function automatic logic [31:0] exc_code(input logic op);
    if (op) begin
      return 32'd5;
    end else begin
      return 32'd4;
    end
  endfunction

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        op_r;
  logic [4:0]  rd_r;
  logic [5:0]  cnt_r;
  logic [4:0]  wb_rd_r;
  logic [31:0] wb_data_r;
  logic        wb_exc_r;
  logic        accept_s;
  logic        rdy_ok_s;
  logic        timeout_s;
  logic        exc_s;

  // Next-state decode; ready is masked for the first two WAIT cycles to drop stale completions.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    rdy_ok_s     = 1'b0;
    timeout_s    = 1'b0;
    exc_s        = 1'b0;
    case (state_r)
      IDLE: begin
        accept_s = bus.req_valid & ~bus.flush;
        if (accept_s) begin
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (bus.flush) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT;
        end
      end
      WAIT: begin
        if (bus.flush) begin
          state_next_s = IDLE;
        end else if (bus.md_rdy && (cnt_r >= CNT_UNMASK)) begin
          rdy_ok_s     = 1'b1;
          exc_s        = op_r ? bus.md_div_exc : bus.md_mult_exc;
          state_next_s = DONE;
        end else if (cnt_r == CNT_LIMIT) begin
          timeout_s    = 1'b1;
          exc_s        = 1'b1;
          state_next_s = DONE;
        end else begin
          state_next_s = WAIT;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand and destination hold registers, loaded on accept and stable until the next accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_r  <= 32'd0;
      b_r  <= 32'd0;
      op_r <= 1'b0;
      rd_r <= 5'd0;
    end else if (accept_s) begin
      a_r  <= bus.req_a;
      b_r  <= bus.req_b;
      op_r <= bus.req_op;
      rd_r <= bus.req_rd;
    end
  end

  // Wait counter: cleared in ISSUE, saturating count through WAIT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r <= 6'd0;
    end else if (state_r == ISSUE) begin
      cnt_r <= 6'd0;
    end else if ((state_r == WAIT) && (cnt_r != CNT_LIMIT)) begin
      cnt_r <= cnt_r + 6'd1;
    end
  end

  // Writeback beat registers, loaded only on the transition into DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_rd_r   <= 5'd0;
      wb_data_r <= 32'd0;
      wb_exc_r  <= 1'b0;
    end else if (rdy_ok_s || timeout_s) begin
      if (exc_s) begin
        wb_rd_r   <= RSTATUS_REG;
        wb_data_r <= exc_code(op_r);
        wb_exc_r  <= 1'b1;
      end else begin
        wb_rd_r   <= rd_r;
        wb_data_r <= bus.md_result;
        wb_exc_r  <= 1'b0;
      end
    end
  end

  // Stall includes the accept cycle itself, so it is gated by reset to read 0 while reset is held.
  assign bus.stall        = reset & (accept_s | (state_r == ISSUE) | (state_r == WAIT));
  assign bus.md_operandA  = a_r;
  assign bus.md_operandB  = b_r;
  assign bus.md_ctrl_MULT = (state_r == ISSUE) & ~op_r;
  assign bus.md_ctrl_DIV  = (state_r == ISSUE) & op_r;
  assign bus.wb_valid     = (state_r == DONE) & ~bus.flush;
  assign bus.wb_rd        = wb_rd_r;
  assign bus.wb_data      = wb_data_r;
  assign bus.wb_exc       = wb_exc_r;
  assign bus.timeout_err  = timeout_s;

endmodule
